// File: rtl/logic_minmax_param_pkg.sv
// Shared definitions for the parametrised MAX/MIN operator: op encodings and
// the field layout of the read-data word.
package logic_minmax_param_pkg;

    typedef enum logic [1:0] {
        OP_UMAX = 2'b00,
        OP_UMIN = 2'b01,
        OP_SMAX = 2'b10,
        OP_SMIN = 2'b11
    } op_e;

    // Result occupies [DATA_WIDTH-1:RES_LSB]; flag offsets are relative to DATA_WIDTH.
    localparam int RES_LSB = 0;
    localparam int Z_BIT   = 0;
    localparam int N_BIT   = 1;
    localparam int V_BIT   = 2;
    localparam int C_BIT   = 3;

    function automatic logic op_is_min(input op_e op);
        return (op == OP_UMIN) || (op == OP_SMIN);
    endfunction

endpackage

// File: rtl/logic_minmax_param_if.sv
// Write/read bus of the MAX/MIN operator block.
interface logic_minmax_param_if #(
    parameter int DATA_WIDTH  = 64,
    parameter int ADDRS_WIDTH = 4
);
    logic                    wren;
    logic [ADDRS_WIDTH-1:0]  wraddrs;
    logic [1:0]              op;
    logic [DATA_WIDTH-1:0]   oprndA;
    logic [DATA_WIDTH-1:0]   oprndB;
    logic                    C;
    logic                    V;
    logic                    rdenA;
    logic [ADDRS_WIDTH-1:0]  rdaddrsA;
    logic [DATA_WIDTH+3:0]   rddataA;
    logic                    rdvalidA;
    logic                    rdenB;
    logic [ADDRS_WIDTH-1:0]  rdaddrsB;
    logic [DATA_WIDTH+3:0]   rddataB;
    logic                    rdvalidB;
    logic                    ready;

    modport slave (
        input  wren, wraddrs, op, oprndA, oprndB, C, V,
               rdenA, rdaddrsA, rdenB, rdaddrsB,
        output rddataA, rdvalidA, rddataB, rdvalidB, ready
    );

    modport master (
        output wren, wraddrs, op, oprndA, oprndB, C, V,
               rdenA, rdaddrsA, rdenB, rdaddrsB,
        input  rddataA, rdvalidA, rddataB, rdvalidB, ready
    );
endinterface

// File: rtl/logic_minmax_param_result_ram.sv
// Per-thread result buffer: one write port, two registered read ports with
// write-first bypass; entries never written since reset read back as zero.
module minmax_result_ram #(
    parameter int ADDRS_WIDTH = 4,
    parameter int WIDTH       = 66
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   wr_en_i,
    input  logic [ADDRS_WIDTH-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]       wr_data_i,
    input  logic                   rd_en_a_i,
    input  logic [ADDRS_WIDTH-1:0] rd_addr_a_i,
    output logic [WIDTH-1:0]       rd_data_a_o,
    output logic                   rd_valid_a_o,
    input  logic                   rd_en_b_i,
    input  logic [ADDRS_WIDTH-1:0] rd_addr_b_i,
    output logic [WIDTH-1:0]       rd_data_b_o,
    output logic                   rd_valid_b_o
);
    localparam int DEPTH = 2 ** ADDRS_WIDTH;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [WIDTH-1:0] rd_data_a_q, rd_data_a_d, rd_data_b_q, rd_data_b_d;
    logic             rd_valid_a_q, rd_valid_a_d, rd_valid_b_q, rd_valid_b_d;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            vld_q <= '0;
        end else if (wr_en_i) begin
            vld_q[wr_addr_i] <= 1'b1;
        end
    end

    // Same-edge commit wins over stored contents.
    always_comb begin
        rd_data_a_d  = vld_q[rd_addr_a_i] ? mem_q[rd_addr_a_i] : '0;
        rd_valid_a_d = vld_q[rd_addr_a_i];
        if (wr_en_i && (wr_addr_i == rd_addr_a_i)) begin
            rd_data_a_d  = wr_data_i;
            rd_valid_a_d = 1'b1;
        end
        rd_data_b_d  = vld_q[rd_addr_b_i] ? mem_q[rd_addr_b_i] : '0;
        rd_valid_b_d = vld_q[rd_addr_b_i];
        if (wr_en_i && (wr_addr_i == rd_addr_b_i)) begin
            rd_data_b_d  = wr_data_i;
            rd_valid_b_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_data_a_q  <= '0;
            rd_valid_a_q <= 1'b0;
            rd_data_b_q  <= '0;
            rd_valid_b_q <= 1'b0;
        end else begin
            if (rd_en_a_i) begin
                rd_data_a_q  <= rd_data_a_d;
                rd_valid_a_q <= rd_valid_a_d;
            end
            if (rd_en_b_i) begin
                rd_data_b_q  <= rd_data_b_d;
                rd_valid_b_q <= rd_valid_b_d;
            end
        end
    end

    assign rd_data_a_o  = rd_data_a_q;
    assign rd_valid_a_o = rd_valid_a_q;
    assign rd_data_b_o  = rd_data_b_q;
    assign rd_valid_b_o = rd_valid_b_q;

endmodule

// File: rtl/logic_minmax_param.sv
// Parametrised MAX/MIN operator (signed/unsigned) with optional compute stage,
// writing {n, z, result} into a dual-read per-thread result buffer.
module logic_minmax_param
    import logic_minmax_param_pkg::*;
#(
    parameter int DATA_WIDTH  = 64,
    parameter int ADDRS_WIDTH = 4,
    parameter int PIPE        = 1
) (
    input  logic CLK,
    input  logic RESET,
    logic_minmax_param_if.slave mm_if
);
    localparam int WORD_W = DATA_WIDTH + 2;

    logic                   wr_en_s;
    logic [ADDRS_WIDTH-1:0] wr_addr_s;
    logic [1:0]             op_s;
    logic [DATA_WIDTH-1:0]  a_s, b_s;

    generate
        if (PIPE != 0) begin : g_pipe
            logic                   pipe_vld_q;
            logic [ADDRS_WIDTH-1:0] pipe_addr_q;
            logic [1:0]             pipe_op_q;
            logic [DATA_WIDTH-1:0]  pipe_a_q, pipe_b_q;

            always_ff @(posedge CLK) begin
                if (!RESET) begin
                    pipe_vld_q  <= 1'b0;
                    pipe_addr_q <= '0;
                    pipe_op_q   <= '0;
                    pipe_a_q    <= '0;
                    pipe_b_q    <= '0;
                end else begin
                    pipe_vld_q <= mm_if.wren;
                    if (mm_if.wren) begin
                        pipe_addr_q <= mm_if.wraddrs;
                        pipe_op_q   <= mm_if.op;
                        pipe_a_q    <= mm_if.oprndA;
                        pipe_b_q    <= mm_if.oprndB;
                    end
                end
            end

            assign wr_en_s   = pipe_vld_q;
            assign wr_addr_s = pipe_addr_q;
            assign op_s      = pipe_op_q;
            assign a_s       = pipe_a_q;
            assign b_s       = pipe_b_q;
        end else begin : g_comb
            assign wr_en_s   = mm_if.wren;
            assign wr_addr_s = mm_if.wraddrs;
            assign op_s      = mm_if.op;
            assign a_s       = mm_if.oprndA;
            assign b_s       = mm_if.oprndB;
        end
    endgenerate

    logic                  a_ge_b, a_le_b, pick_a;
    logic [DATA_WIDTH-1:0] result;
    logic [WORD_W-1:0]     wr_word;

    // Ties select A for both MAX and MIN.
    always_comb begin
        a_ge_b = 1'b0;
        a_le_b = 1'b0;
        unique case (op_e'(op_s))
            OP_UMAX, OP_UMIN: begin
                a_ge_b = a_s >= b_s;
                a_le_b = a_s <= b_s;
            end
            OP_SMAX, OP_SMIN: begin
                a_ge_b = $signed(a_s) >= $signed(b_s);
                a_le_b = $signed(a_s) <= $signed(b_s);
            end
            default: ;
        endcase
        pick_a = op_is_min(op_e'(op_s)) ? a_le_b : a_ge_b;
        result = pick_a ? a_s : b_s;

        wr_word = '0;
        wr_word[RES_LSB +: DATA_WIDTH]  = result;
        wr_word[DATA_WIDTH + Z_BIT]     = (a_s == b_s);
        wr_word[DATA_WIDTH + N_BIT]     = result[DATA_WIDTH-1];
    end

    logic [WORD_W-1:0] rd_word_a, rd_word_b;

    minmax_result_ram #(
        .ADDRS_WIDTH (ADDRS_WIDTH),
        .WIDTH       (WORD_W)
    ) u_ram (
        .clk_i        (CLK),
        .rst_ni       (RESET),
        .wr_en_i      (wr_en_s),
        .wr_addr_i    (wr_addr_s),
        .wr_data_i    (wr_word),
        .rd_en_a_i    (mm_if.rdenA),
        .rd_addr_a_i  (mm_if.rdaddrsA),
        .rd_data_a_o  (rd_word_a),
        .rd_valid_a_o (mm_if.rdvalidA),
        .rd_en_b_i    (mm_if.rdenB),
        .rd_addr_b_i  (mm_if.rdaddrsB),
        .rd_data_b_o  (rd_word_b),
        .rd_valid_b_o (mm_if.rdvalidB)
    );

    // C and V bypass the buffer and reflect the live inputs.
    always_comb begin
        mm_if.rddataA = {rd_word_a[WORD_W-1:0], 2'b00} >> 2;
        mm_if.rddataA[DATA_WIDTH + C_BIT] = mm_if.C;
        mm_if.rddataA[DATA_WIDTH + V_BIT] = mm_if.V;
        mm_if.rddataB = {rd_word_b[WORD_W-1:0], 2'b00} >> 2;
        mm_if.rddataB[DATA_WIDTH + C_BIT] = mm_if.C;
        mm_if.rddataB[DATA_WIDTH + V_BIT] = mm_if.V;
    end

    logic ready_q, ready_d;

    assign ready_d = !(mm_if.wren && (mm_if.rdenA || mm_if.rdenB));

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            ready_q <= 1'b1;
        end else begin
            ready_q <= ready_d;
        end
    end

    assign mm_if.ready = ready_q;

endmodule

// File: doc/logic_minmax_param.md
Name: logic_minmax_param

Overview:
- Parametrised successor to the fixed 64-bit MAX operator.
- Computes MAX or MIN of two operands, signed or unsigned, selectable per write.
- Optional one-stage compute pipeline; result written into a per-thread result buffer with n/z flags.
- Buffer read over two independent registered ports (A, B) that return {C, V, n, z, result}; sits among the CPU's memory-mapped operator blocks.

Parameters:
DATA_WIDTH, 64, operand and result width (>=8)
ADDRS_WIDTH, 4, result-buffer address width (thread# included); depth = 2**ADDRS_WIDTH
PIPE, 1, 0 = compute and write in the wren cycle; 1 = one register stage before buffer write

Ports:
CLK  input  1  clock; all logic on rising edge
RESET  input  1  reset; synchronous, active-low
wren  input  1  write strobe: capture operands and op
wraddrs  input  ADDRS_WIDTH  destination buffer entry
op  input  2  00 unsigned MAX, 01 unsigned MIN, 10 signed MAX, 11 signed MIN
oprndA  input  DATA_WIDTH  operand A
oprndB  input  DATA_WIDTH  operand B
C  input  1  carry flag, passed through to read data
V  input  1  overflow flag, passed through to read data
rdenA  input  1  read enable, port A
rdaddrsA  input  ADDRS_WIDTH  read address, port A
rddataA  output  DATA_WIDTH+4  {C, V, n, z, result}, port A
rdvalidA  output  1  addressed entry written since reset, port A
rdenB  input  1  read enable, port B
rdaddrsB  input  ADDRS_WIDTH  read address, port B
rddataB  output  DATA_WIDTH+4  {C, V, n, z, result}, port B
rdvalidB  output  1  addressed entry written since reset, port B
ready  output  1  block ready

Behaviour:
- Reset (RESET low at a rising edge):
  - rddataA/B stored fields, rdvalidA/B and all entry valid bits cleared to 0.
  - Pipeline valid cleared; an in-flight PIPE=1 write is discarded.
  - ready = 1.
  - Buffer data contents are don't-care; entries are masked by valid bits.
- Compare rules:
  - Unsigned: plain magnitude compare.
  - Signed: two's complement compare.
  - MAX selects A when A >= B, else B. MIN selects A when A <= B, else B. Ties therefore select A.
- Flags: n = result[DATA_WIDTH-1]; z = (oprndA == oprndB), bitwise equality, independent of op.
- Write commit timing:
  - PIPE=0: entry wraddrs and its valid bit update at the edge ending the wren cycle T.
  - PIPE=1: operands, op and wraddrs registered at edge T; entry and valid bit update at edge T+1.
  - Back-to-back wren every cycle is supported at full rate in both modes.
- Read timing:
  - rdenX high in cycle R: the entry is captured at edge R; rddataX and rdvalidX are valid from R+1.
  - With rdenX low, rddataX/rdvalidX hold their last value.
- Write-first bypass: if a commit and a read of the same address occur at the same edge, the read returns the newly committed result and rdvalid = 1. A read of an entry whose commit is still pending (PIPE=1, stage full) returns the old contents.
- C and V are not stored. rddataX[DATA_WIDTH+3:DATA_WIDTH+2] = live {C, V} inputs, combinational pass-through.
- Ports A and B may read the same or different addresses in the same cycle, with no interaction.
- ready:
  - Registered; becomes 0 for the cycle after any cycle with wren && (rdenA || rdenB), otherwise 1.
  - It is advisory; the block still performs both the write and the read.
- Address wrap: addresses are taken modulo depth; no out-of-range case exists.

Decomposition:
- Shared package: op encodings (OP_UMAX, OP_UMIN, OP_SMAX, OP_SMIN) and the rddata field-offset constants (RES_LSB, Z_BIT, N_BIT, V_BIT, C_BIT).
- One sub-module, minmax_result_ram:
  - One write port and two registered read ports, with write-first bypass and per-entry valid bits.
  - Parametrised by ADDRS_WIDTH and DATA_WIDTH+2.
- Compare/select and flag generation stay in the top level.

Test Plan:
- Reset then read addr 3 on A → rddataA result/flags = 0, rdvalidA = 0, ready = 1.
- DATA_WIDTH=64, PIPE=0, op=00, A=0x8000_0000_0000_0001, B=0x7FFF_FFFF_FFFF_FFFF, wraddrs=5, then read 5 on port A → result = A, n=1, z=0, rdvalidA=1. Repeat with op=10 → result = B, n=0.
- PIPE=1, wren op=01 A=B=0x10 addr 2 in cycle T; rdenB addr 2 in T → old contents; in T+1 (same-edge commit) → result 0x10, z=1, n=0.
- wren and rdenA in the same cycle → ready = 0 the next cycle and 1 after; 8 back-to-back writes to addrs 0..7 read back correctly on both ports simultaneously.
- With C=1, V=0 held, port A reads addr 7 and port B reads addr 7 in the same cycle → identical rddata with bits [67:66] = 2'b10.
- Assert RESET during a PIPE=1 in-flight write to addr 9, then read addr 9 → rdvalid = 0.
